hazard_unit_mc: RTL and testbench

//  Next-gen hazard/forwarding unit for the 5-stage MIPS pipeline. It handles:
//  - E- and D-stage forwarding.
//  - Load-use and branch stalls.
//  - Multi-cycle data-cache miss freeze through a small FSM with watchdog.
//  - Multi-cycle multiplier scoreboard that guards HI/LO reads and back-to-back mults.

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_unit_mc_if.sv | 25 ++
 rtl/mult_scoreboard.sv | 20 ++
 rtl/hazard_unit_mc.sv | 93 +++++++++
 tb/tb_hazard_unit_mc.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding-select codes and memory-miss FSM states for hazard_unit_mc
package hazard_pkg;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    typedef enum logic {IDLE, MISS} mem_state_t;
endpackage

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: pipeline-to-hazard-unit bundle; master is the datapath, slave is the hazard unit
interface hazard_unit_mc_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic reg_write_e, reg_write_m, reg_write_w;
    logic mem_to_reg_e, mem_to_reg_m, mem_write_m, mem_ready;
    logic branch_d, mult_start_d, mult_start_e, hilo_read_d;
    logic [1:0] forward_ae, forward_be;
    logic forward_ad, forward_bd;
    logic stall_f, stall_d, stall_e, stall_m, stall_w, flush_e;
    logic mult_busy, mem_timeout;
    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               mem_write_m, mem_ready, branch_d, mult_start_d, mult_start_e, hilo_read_d,
        input  forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d,
               stall_e, stall_m, stall_w, flush_e, mult_busy, mem_timeout
    );
    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               mem_write_m, mem_ready, branch_d, mult_start_d, mult_start_e, hilo_read_d,
        output forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d,
               stall_e, stall_m, stall_w, flush_e, mult_busy, mem_timeout
    );
endinterface

// File: rtl/mult_scoreboard.sv
// mult_scoreboard: down-counter tracking an in-flight multiply; runs regardless of pipeline freezes
module mult_scoreboard #(
    parameter int MULT_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic busy
);
    localparam int W = $clog2(MULT_LAT);
    logic [W-1:0] cnt;
    // load on an unheld issue, otherwise count down until the result is ready
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (cnt != '0) cnt <= cnt - W'(1);
        else if (start && !hold) cnt <= W'(MULT_LAT - 1);
    end
    assign busy = cnt != '0;
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, stall/flush control, cache-miss freeze with watchdog and mult scoreboard; HAZARD_PERF_EN adds perf_stall_cnt
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int MULT_LAT     = 32,
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cnt,
`endif
    hazard_unit_mc_if.slave bus
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(MISS_TIMEOUT);
    mem_state_t state, state_n;
    logic [CNT_W-1:0] miss_cnt;
    logic miss, mem_stall, lw_stall, br_stall, mul_stall, hz_stall, busy;

    function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
        return src != '0 && src == dst;
    endfunction

    function automatic logic [1:0] fwd(input logic m, input logic w);
        return m ? FWD_MEM : w ? FWD_WB : FWD_NONE;
    endfunction

    assign bus.forward_ae = reset ? FWD_NONE : fwd(hit(bus.rs_e, bus.write_reg_m) && bus.reg_write_m,
                                                   hit(bus.rs_e, bus.write_reg_w) && bus.reg_write_w);
    assign bus.forward_be = reset ? FWD_NONE : fwd(hit(bus.rt_e, bus.write_reg_m) && bus.reg_write_m,
                                                   hit(bus.rt_e, bus.write_reg_w) && bus.reg_write_w);
    assign bus.forward_ad = !reset && hit(bus.rs_d, bus.write_reg_m) && bus.reg_write_m;
    assign bus.forward_bd = !reset && hit(bus.rt_d, bus.write_reg_m) && bus.reg_write_m;

    assign lw_stall  = bus.mem_to_reg_e && (hit(bus.rs_d, bus.write_reg_e) || hit(bus.rt_d, bus.write_reg_e));
    assign br_stall  = bus.branch_d &&
                       ((bus.reg_write_e && (hit(bus.rs_d, bus.write_reg_e) || hit(bus.rt_d, bus.write_reg_e))) ||
                        (bus.mem_to_reg_m && (hit(bus.rs_d, bus.write_reg_m) || hit(bus.rt_d, bus.write_reg_m))));
    assign mul_stall = (bus.hilo_read_d || bus.mult_start_d) && (busy || bus.mult_start_e);
    assign hz_stall  = lw_stall || br_stall || mul_stall;
    assign miss      = (bus.mem_to_reg_m || bus.mem_write_m) && !bus.mem_ready;

    // a cache miss freezes the whole pipe and overrides the bubble-inserting stalls
    assign bus.stall_f   = !reset && (mem_stall || hz_stall);
    assign bus.stall_d   = !reset && (mem_stall || hz_stall);
    assign bus.stall_e   = !reset && mem_stall;
    assign bus.stall_m   = !reset && mem_stall;
    assign bus.stall_w   = !reset && mem_stall;
    assign bus.flush_e   = !reset && !mem_stall && hz_stall;
    assign bus.mult_busy = !reset && busy;

    // miss FSM next state; the freeze is combinational so it covers the miss cycle itself
    always_comb begin
        state_n   = state;
        mem_stall = 1'b0;
        state_n   = state == IDLE ? (miss ? MISS : IDLE) : (bus.mem_ready ? IDLE : MISS);
        mem_stall = state == IDLE ? miss : !bus.mem_ready;
    end

    // miss state, saturating watchdog counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            miss_cnt        <= '0;
            bus.mem_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == MISS) miss_cnt <= '0;
            else if (state == MISS && !bus.mem_ready && miss_cnt != TMO) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
                if (miss_cnt + CNT_W'(1) == TMO) bus.mem_timeout <= 1'b1;
            end
        end
    end

    mult_scoreboard #(.MULT_LAT(MULT_LAT)) u_sb (
        .clk  (clk),
        .reset(reset),
        .start(bus.mult_start_e),
        .hold (bus.stall_e),
        .busy (busy)
    );

`ifdef HAZARD_PERF_EN
    // saturating count of fetch-stall cycles
    always_ff @(posedge clk) begin
        if (reset) perf_stall_cnt <= '0;
        else if (bus.stall_f && perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed self-checking bench for hazard_unit_mc with MULT_LAT=4, MISS_TIMEOUT=3
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] stv;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    hazard_unit_mc_if #(.REG_AW(5)) bus ();

    hazard_unit_mc #(.REG_AW(5), .MULT_LAT(4), .MISS_TIMEOUT(3), .CNT_W(8)) dut (
        .clk  (clk),
        .reset(reset),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign stv = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_e};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.rs_d = 0; bus.rt_d = 0; bus.rs_e = 0; bus.rt_e = 0;
        bus.write_reg_e = 0; bus.write_reg_m = 0; bus.write_reg_w = 0;
        bus.reg_write_e = 0; bus.reg_write_m = 0; bus.reg_write_w = 0;
        bus.mem_to_reg_e = 0; bus.mem_to_reg_m = 0; bus.mem_write_m = 0; bus.mem_ready = 1;
        bus.branch_d = 0; bus.mult_start_d = 0; bus.mult_start_e = 0; bus.hilo_read_d = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear();
        step(); step();
        n_cmp++; if ({stv, bus.mult_busy, bus.mem_timeout} !== 8'h00) begin n_bad++; $display("FAIL rst_outs: got %b want 00000000", {stv, bus.mult_busy, bus.mem_timeout}); end
        bus.mem_to_reg_m = 1; bus.mem_ready = 0; bus.rs_e = 3; bus.write_reg_m = 3; bus.reg_write_m = 1;
        #1;
        n_cmp++; if ({stv, bus.forward_ae} !== 8'h00) begin n_bad++; $display("FAIL rst_gated: got %b want 00000000", {stv, bus.forward_ae}); end
        clear(); reset = 0; step();
        n_cmp++; if ({stv, bus.mult_busy, bus.mem_timeout} !== 8'h00) begin n_bad++; $display("FAIL post_rst: got %b want 00000000", {stv, bus.mult_busy, bus.mem_timeout}); end
    endtask

    task automatic test_forward_e();
        clear();
        bus.write_reg_m = 3; bus.reg_write_m = 1; bus.rs_e = 3; #1;
        n_cmp++; if (bus.forward_ae !== 2'b10) begin n_bad++; $display("FAIL fwd_ae_m: got %b want 10", bus.forward_ae); end
        bus.write_reg_w = 3; bus.reg_write_w = 1; #1;
        n_cmp++; if (bus.forward_ae !== 2'b10) begin n_bad++; $display("FAIL fwd_ae_m_over_w: got %b want 10", bus.forward_ae); end
        bus.rs_e = 0; bus.write_reg_m = 0; bus.write_reg_w = 0; #1;
        n_cmp++; if (bus.forward_ae !== 2'b00) begin n_bad++; $display("FAIL fwd_ae_r0: got %b want 00", bus.forward_ae); end
        bus.write_reg_m = 3; bus.reg_write_m = 0; bus.write_reg_w = 3; bus.reg_write_w = 1; bus.rt_e = 3; #1;
        n_cmp++; if (bus.forward_be !== 2'b01) begin n_bad++; $display("FAIL fwd_be_w_no_rw_m: got %b want 01", bus.forward_be); end
        bus.reg_write_w = 0; #1;
        n_cmp++; if (bus.forward_be !== 2'b00) begin n_bad++; $display("FAIL fwd_be_no_rw: got %b want 00", bus.forward_be); end
    endtask

    task automatic test_load_use();
        clear();
        bus.mem_to_reg_e = 1; bus.reg_write_e = 1; bus.write_reg_e = 4; bus.rt_d = 4; #1;
        n_cmp++; if (stv !== 6'b110001) begin n_bad++; $display("FAIL lw_stall: got %b want 110001", stv); end
        step();
        bus.mem_to_reg_e = 0; bus.reg_write_e = 0; bus.write_reg_e = 0;
        bus.mem_to_reg_m = 1; bus.reg_write_m = 1; bus.write_reg_m = 4; #1;
        n_cmp++; if ({stv, bus.forward_bd} !== 7'b0000001) begin n_bad++; $display("FAIL lw_release: got %b want 0000001", {stv, bus.forward_bd}); end
        step();
        bus.mem_to_reg_m = 0; bus.reg_write_m = 0; bus.write_reg_m = 0; bus.rt_d = 0;
        bus.reg_write_w = 1; bus.write_reg_w = 4; bus.rt_e = 4; #1;
        n_cmp++; if (bus.forward_be !== 2'b01) begin n_bad++; $display("FAIL lw_fwd_w: got %b want 01", bus.forward_be); end
        clear(); bus.mem_to_reg_e = 1; bus.write_reg_e = 0; bus.rt_d = 0; #1;
        n_cmp++; if (stv !== 6'b000000) begin n_bad++; $display("FAIL lw_r0: got %b want 000000", stv); end
    endtask

    task automatic test_branch();
        clear();
        bus.branch_d = 1; bus.rs_d = 5; bus.reg_write_e = 1; bus.write_reg_e = 5; #1;
        n_cmp++; if (stv !== 6'b110001) begin n_bad++; $display("FAIL br_stall_e: got %b want 110001", stv); end
        step();
        bus.reg_write_e = 0; bus.write_reg_e = 0; bus.reg_write_m = 1; bus.write_reg_m = 5; #1;
        n_cmp++; if ({stv, bus.forward_ad, bus.forward_bd} !== 8'b00000010) begin n_bad++; $display("FAIL br_fwd_ad: got %b want 00000010", {stv, bus.forward_ad, bus.forward_bd}); end
        bus.mem_to_reg_m = 1; #1;
        n_cmp++; if (stv !== 6'b110001) begin n_bad++; $display("FAIL br_stall_lw_m: got %b want 110001", stv); end
        clear(); bus.branch_d = 1; bus.reg_write_e = 1; #1;
        n_cmp++; if (stv !== 6'b000000) begin n_bad++; $display("FAIL br_r0: got %b want 000000", stv); end
    endtask

    task automatic test_mult();
        clear(); step();
        bus.mult_start_e = 1; bus.hilo_read_d = 1; #1;
        n_cmp++; if ({bus.stall_d, bus.flush_e, bus.mult_busy} !== 3'b110) begin n_bad++; $display("FAIL mul_issue: got %b want 110", {bus.stall_d, bus.flush_e, bus.mult_busy}); end
        step(); bus.mult_start_e = 0; #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({bus.stall_d, bus.flush_e, bus.mult_busy} !== 3'b111) begin n_bad++; $display("FAIL mul_busy_%0d: got %b want 111", i, {bus.stall_d, bus.flush_e, bus.mult_busy}); end
            step();
        end
        n_cmp++; if ({bus.stall_d, bus.flush_e, bus.mult_busy} !== 3'b000) begin n_bad++; $display("FAIL mul_done: got %b want 000", {bus.stall_d, bus.flush_e, bus.mult_busy}); end
    endtask

    task automatic test_back_to_back();
        clear(); step();
        bus.mult_start_e = 1; bus.mult_start_d = 1; #1;
        n_cmp++; if (bus.stall_d !== 1'b1) begin n_bad++; $display("FAIL b2b_stall: got %b want 1", bus.stall_d); end
        step(); bus.mult_start_e = 0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if ({bus.stall_d, bus.mult_busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_free: got %b want 00", {bus.stall_d, bus.mult_busy}); end
        step(); bus.mult_start_d = 0; bus.mult_start_e = 1; step(); bus.mult_start_e = 0; #1;
        n_cmp++; if (bus.mult_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got %b want 1", bus.mult_busy); end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_mult_freeze();
        clear(); step();
        bus.mult_start_e = 1; bus.mem_to_reg_m = 1; bus.mem_ready = 0; step();
        n_cmp++; if (bus.mult_busy !== 1'b0) begin n_bad++; $display("FAIL mulf_held: got %b want 0", bus.mult_busy); end
        bus.mem_ready = 1; step();
        bus.mult_start_e = 0; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({bus.stall_e, bus.mult_busy} !== 2'b11) begin n_bad++; $display("FAIL mulf_run_%0d: got %b want 11", i, {bus.stall_e, bus.mult_busy}); end
            step();
        end
        n_cmp++; if ({bus.stall_e, bus.mult_busy} !== 2'b10) begin n_bad++; $display("FAIL mulf_done: got %b want 10", {bus.stall_e, bus.mult_busy}); end
        bus.mem_ready = 1; step(); clear();
    endtask

    task automatic test_mem_miss();
        clear();
        bus.mem_to_reg_m = 1; bus.mem_ready = 0;
        bus.mem_to_reg_e = 1; bus.reg_write_e = 1; bus.write_reg_e = 4; bus.rt_d = 4;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (stv !== 6'b111110) begin n_bad++; $display("FAIL miss_freeze_%0d: got %b want 111110", i, stv); end
            step();
        end
        bus.mem_ready = 1; #1;
        n_cmp++; if (stv !== 6'b110001) begin n_bad++; $display("FAIL miss_ready_lw: got %b want 110001", stv); end
        step(); clear(); #1;
        n_cmp++; if (stv !== 6'b000000) begin n_bad++; $display("FAIL miss_idle: got %b want 000000", stv); end
    endtask

    task automatic test_timeout();
        reset = 1; clear(); step(); reset = 0; step();
        n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_init: got %b want 0", bus.mem_timeout); end
        bus.mem_write_m = 1; bus.mem_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++; if (bus.mem_timeout !== (i >= 4)) begin n_bad++; $display("FAIL tmo_edge_%0d: got %b want %b", i, bus.mem_timeout, (i >= 4)); end
        end
        bus.mem_ready = 1; step(); bus.mem_ready = 0; #1;
        n_cmp++; if ({bus.mem_timeout, bus.stall_f} !== 2'b11) begin n_bad++; $display("FAIL tmo_sticky: got %b want 11", {bus.mem_timeout, bus.stall_f}); end
        step(); reset = 1; step();
        n_cmp++; if ({bus.mem_timeout, bus.stall_f} !== 2'b00) begin n_bad++; $display("FAIL tmo_reset: got %b want 00", {bus.mem_timeout, bus.stall_f}); end
        reset = 0; clear(); step();
        n_cmp++; if ({stv, bus.mem_timeout} !== 7'b0) begin n_bad++; $display("FAIL tmo_after: got %b want 0000000", {stv, bus.mem_timeout}); end
    endtask

    initial begin
        clear();
        test_reset();
        test_forward_e();
        test_load_use();
        test_branch();
        test_mult();
        test_back_to_back();
        test_mult_freeze();
        test_mem_miss();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
